debug_controller: RTL and testbench

DEBUG_CONTROLLER -- requirements
Module: debug_controller

---
 rtl/debug_pkg.sv | 20 ++
 rtl/debug_cmd_decode.sv | 23 ++
 rtl/debug_controller.sv | 136 +++++++++++++
 tb/tb_debug_controller.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// debug_pkg: state encoding, default command bytes and WAIT blanking length for the debug controller
package debug_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_STEP,
      S_SEND,
      S_WAIT,
      S_HALTED
   } state_e;

   localparam logic [7:0] CMD_CONT_DEF = 8'h63;
   localparam logic [7:0] CMD_STEP_DEF = 8'h73;
   localparam logic [7:0] CMD_RST_DEF  = 8'h72;

   // cycles at the start of WAIT during which dataSent is ignored
   localparam logic [1:0] BLANK_LEN = 2'd2;

endpackage

// File: rtl/debug_cmd_decode.sv
// debug_cmd_decode: turns a received UART byte into one-hot cont/step/rst command pulses
module debug_cmd_decode
   import debug_pkg::*;
#(
   parameter logic [7:0] CMD_CONT = CMD_CONT_DEF,
   parameter logic [7:0] CMD_STEP = CMD_STEP_DEF,
   parameter logic [7:0] CMD_RST  = CMD_RST_DEF
) (
   input  logic       rx_done_tick,
   input  logic [7:0] r_data,
   output logic       cont,
   output logic       step,
   output logic       rst
);

   // a byte only counts while its done tick is high
   always_comb begin
      cont = rx_done_tick && (r_data == CMD_CONT);
      step = rx_done_tick && (r_data == CMD_STEP);
      rst  = rx_done_tick && (r_data == CMD_RST);
   end

endmodule

// File: rtl/debug_controller.sv
// debug_controller: UART-driven run/step/reset control of a CPU with a frame-send handshake; DEBUG_CYCLE_COUNT_EN adds cycle_count
module debug_controller
   import debug_pkg::*;
#(
   parameter logic [7:0] CMD_CONT = CMD_CONT_DEF,
   parameter logic [7:0] CMD_STEP = CMD_STEP_DEF,
   parameter logic [7:0] CMD_RST  = CMD_RST_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_done_tick,
   input  logic [7:0]  r_data,
   input  logic        halt,
   input  logic        dataSent,
   output logic        cpu_en,
   output logic        cpu_reset,
   output logic        sendSignal,
   output logic        busy
`ifdef DEBUG_CYCLE_COUNT_EN
   ,
   output logic [15:0] cycle_count
`endif
);

   logic   cmd_cont, cmd_step, cmd_rst;
   state_e state_q, state_d;
   logic   cpu_en_q, cpu_en_d;
   logic   cpu_reset_q, cpu_reset_d;
   logic   send_q, send_d;
   logic   busy_q, busy_d;
   logic   halted_q, halted_d;
   logic [1:0] blank_q, blank_d;

   debug_cmd_decode #(
      .CMD_CONT(CMD_CONT),
      .CMD_STEP(CMD_STEP),
      .CMD_RST (CMD_RST)
   ) u_dec (
      .rx_done_tick(rx_done_tick),
      .r_data      (r_data),
      .cont        (cmd_cont),
      .step        (cmd_step),
      .rst         (cmd_rst)
   );

   // next state and next registered outputs; cpu_en in RUN lags entry by one cycle so halt already high runs nothing
   always_comb begin
      state_d     = state_q;
      cpu_en_d    = 1'b0;
      cpu_reset_d = 1'b0;
      send_d      = 1'b0;
      halted_d    = halted_q;
      blank_d     = blank_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_rst) cpu_reset_d = 1'b1;
            else if (cmd_cont) state_d = S_RUN;
            else if (cmd_step) begin
               state_d  = S_STEP;
               cpu_en_d = 1'b1;
            end
         end
         S_RUN: begin
            if (halt) begin
               state_d  = S_SEND;
               send_d   = 1'b1;
               halted_d = 1'b1;
            end else cpu_en_d = 1'b1;
         end
         S_STEP: begin
            state_d  = S_SEND;
            send_d   = 1'b1;
            halted_d = halt;
         end
         S_SEND: begin
            state_d = S_WAIT;
            blank_d = 2'd0;
         end
         S_WAIT: begin
            if (blank_q < BLANK_LEN) blank_d = blank_q + 2'd1;
            else if (dataSent) state_d = halted_q ? S_HALTED : S_IDLE;
         end
         S_HALTED: begin
            if (cmd_rst) begin
               state_d     = S_IDLE;
               cpu_reset_d = 1'b1;
               halted_d    = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = !(state_d inside {S_IDLE, S_HALTED});
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cpu_en_q    <= 1'b0;
         cpu_reset_q <= 1'b0;
         send_q      <= 1'b0;
         busy_q      <= 1'b0;
         halted_q    <= 1'b0;
         blank_q     <= 2'd0;
      end else begin
         state_q     <= state_d;
         cpu_en_q    <= cpu_en_d;
         cpu_reset_q <= cpu_reset_d;
         send_q      <= send_d;
         busy_q      <= busy_d;
         halted_q    <= halted_d;
         blank_q     <= blank_d;
      end
   end

   assign cpu_en     = cpu_en_q;
   assign cpu_reset  = cpu_reset_q;
   assign sendSignal = send_q;
   assign busy       = busy_q;

`ifdef DEBUG_CYCLE_COUNT_EN
   logic [15:0] cnt_q, cnt_d;

   // counts enabled CPU cycles, wraps naturally, cleared by a CPU reset pulse
   always_comb cnt_d = cpu_reset_q ? 16'd0 : cnt_q + {15'd0, cpu_en_q};

   // counter register
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= 16'd0;
      else cnt_q <= cnt_d;
   end

   assign cycle_count = cnt_q;
`endif

endmodule

// File: tb/tb_debug_controller.sv
// tb_debug_controller: vector table plus directed sequences for debug_controller
module tb_debug_controller;

   localparam logic [7:0] B_CONT = 8'h63;
   localparam logic [7:0] B_STEP = 8'h73;
   localparam logic [7:0] B_RST  = 8'h72;

   typedef struct packed {
      logic en;
      logic rst;
      logic snd;
      logic busy;
   } outs_t;

   typedef struct packed {
      logic [7:0] b;
      logic       tk;
      logic       hl;
      outs_t      e1;
      outs_t      e2;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rx_done_tick = 1'b0;
   logic [7:0] r_data = 8'h00;
   logic halt = 1'b0;
   logic dataSent = 1'b0;
   logic cpu_en, cpu_reset, sendSignal, busy;
`ifdef DEBUG_CYCLE_COUNT_EN
   logic [15:0] cycle_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int overlap = 0;
   vec_t  vec [9];
   outs_t sb [$];

   always #5 clk = ~clk;

   debug_controller dut (
      .clk         (clk),
      .reset       (reset),
      .rx_done_tick(rx_done_tick),
      .r_data      (r_data),
      .halt        (halt),
      .dataSent    (dataSent),
      .cpu_en      (cpu_en),
      .cpu_reset   (cpu_reset),
      .sendSignal  (sendSignal),
      .busy        (busy)
`ifdef DEBUG_CYCLE_COUNT_EN
      ,
      .cycle_count (cycle_count)
`endif
   );

   always @(negedge clk) if (cpu_en && sendSignal) overlap++;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, 16'(act), 16'(exp));
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic tk);
      r_data = b;
      rx_done_tick = tk;
      cyc();
      rx_done_tick = 1'b0;
      r_data = 8'h00;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      dataSent = 1'b1;
      while (busy && k < 50) begin
         cyc();
         k++;
      end
      dataSent = 1'b0;
      chk1(name, busy, 1'b0);
   endtask

   task automatic drain(input string name);
      halt = 1'b1;
      wait_idle(name);
      halt = 1'b0;
      send_byte(B_RST, 1'b1);
      cyc();
   endtask

   initial begin
      int en_cnt, snd_cnt, busy_cnt, i;
      outs_t e;
      vec = '{
         {8'h78,  1'b1, 1'b0, 4'b0000, 4'b0000},
         {B_RST,  1'b1, 1'b0, 4'b0100, 4'b0000},
         {B_STEP, 1'b0, 1'b0, 4'b0000, 4'b0000},
         {B_STEP, 1'b1, 1'b0, 4'b1001, 4'b0011},
         {B_CONT, 1'b1, 1'b1, 4'b0001, 4'b0011},
         {B_CONT, 1'b1, 1'b0, 4'b0001, 4'b1001},
         {8'h43,  1'b1, 1'b0, 4'b0000, 4'b0000},
         {8'hFF,  1'b1, 1'b0, 4'b0000, 4'b0000},
         {B_RST,  1'b0, 1'b0, 4'b0000, 4'b0000}
      };

      cyc();
      do_reset();
      chk1("rst_en", cpu_en, 1'b0);
      chk1("rst_cpu_reset", cpu_reset, 1'b0);
      chk1("rst_send", sendSignal, 1'b0);
      chk1("rst_busy", busy, 1'b0);
`ifdef DEBUG_CYCLE_COUNT_EN
      chk("rst_cycle_count", cycle_count, 16'd0);
`endif

      foreach (vec[v]) begin
         halt = vec[v].hl;
         sb.push_back(vec[v].e1);
         sb.push_back(vec[v].e2);
         send_byte(vec[v].b, vec[v].tk);
         for (int c = 0; c < 2; c++) begin
            e = sb.pop_front();
            chk1($sformatf("v%0d_c%0d_en", v, c), cpu_en, e.en);
            chk1($sformatf("v%0d_c%0d_rst", v, c), cpu_reset, e.rst);
            chk1($sformatf("v%0d_c%0d_snd", v, c), sendSignal, e.snd);
            chk1($sformatf("v%0d_c%0d_busy", v, c), busy, e.busy);
            cyc();
         end
         drain($sformatf("v%0d_drain", v));
      end

      do_reset();
      send_byte(B_STEP, 1'b1);
      chk1("step_en1", cpu_en, 1'b1);
      chk1("step_snd1", sendSignal, 1'b0);
      cyc();
      chk1("step_en2", cpu_en, 1'b0);
      chk1("step_snd2", sendSignal, 1'b1);
      cyc();
      chk1("step_snd3", sendSignal, 1'b0);
      chk1("step_busy3", busy, 1'b1);
      cyc();
      cyc();
      dataSent = 1'b1;
      cyc();
      dataSent = 1'b0;
      chk1("step_idle", busy, 1'b0);

      halt = 1'b0;
      send_byte(B_CONT, 1'b1);
      en_cnt = 0;
      snd_cnt = 0;
      i = 0;
      while (snd_cnt == 0 && i < 200) begin
         if (cpu_en) en_cnt++;
         if (sendSignal) snd_cnt++;
         if (en_cnt == 40) halt = 1'b1;
         cyc();
         i++;
      end
      for (int k = 0; k < 5; k++) begin
         if (cpu_en) en_cnt++;
         if (sendSignal) snd_cnt++;
         cyc();
      end
      wait_idle("run_done");
      chk("run_en_cycles", 16'(en_cnt), 16'd40);
      chk("run_send_pulses", 16'(snd_cnt), 16'd1);
      send_byte(B_STEP, 1'b1);
      chk1("halted_step_en", cpu_en, 1'b0);
      chk1("halted_step_busy", busy, 1'b0);
      cyc();
      chk1("halted_step_snd", sendSignal, 1'b0);

      send_byte(B_RST, 1'b1);
      chk1("halted_r_pulse", cpu_reset, 1'b1);
      chk1("halted_r_busy", busy, 1'b0);
      cyc();
      chk1("halted_r_pulse_end", cpu_reset, 1'b0);
      halt = 1'b0;
      send_byte(B_STEP, 1'b1);
      chk1("after_r_step1_en", cpu_en, 1'b1);
      wait_idle("after_r_step1_idle");
      send_byte(B_STEP, 1'b1);
      chk1("after_r_step2_en", cpu_en, 1'b1);
      wait_idle("after_r_step2_idle");

      send_byte(B_STEP, 1'b1);
      cyc();
      dataSent = 1'b1;
      cyc();
      cyc();
      dataSent = 1'b0;
      cyc();
      cyc();
      cyc();
      chk1("blank_held_no_exit", busy, 1'b1);
      dataSent = 1'b1;
      cyc();
      dataSent = 1'b0;
      chk1("blank_first_exit", busy, 1'b0);

      send_byte(B_STEP, 1'b1);
      cyc();
      dataSent = 1'b1;
      cyc();
      cyc();
      cyc();
      chk1("blank_cont_still_wait", busy, 1'b1);
      cyc();
      chk1("blank_cont_exit", busy, 1'b0);
      dataSent = 1'b0;

      halt = 1'b0;
      send_byte(B_CONT, 1'b1);
      en_cnt = 0;
      i = 0;
      while (en_cnt < 10 && i < 50) begin
         cyc();
         if (cpu_en) en_cnt++;
         i++;
      end
      chk("midrun_reached", 16'(en_cnt), 16'd10);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk1("midrun_en", cpu_en, 1'b0);
      chk1("midrun_snd", sendSignal, 1'b0);
      chk1("midrun_busy", busy, 1'b0);
      chk1("midrun_cpu_reset", cpu_reset, 1'b0);
`ifdef DEBUG_CYCLE_COUNT_EN
      chk("midrun_cycle_count", cycle_count, 16'd0);
`endif
      halt = 1'b1;
      snd_cnt = 0;
      busy_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (sendSignal) snd_cnt++;
         if (busy || cpu_en) busy_cnt++;
      end
      halt = 1'b0;
      chk("midrun_no_send", 16'(snd_cnt), 16'd0);
      chk("midrun_stays_idle", 16'(busy_cnt), 16'd0);

      send_byte(B_STEP, 1'b1);
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      dataSent = 1'b1;
      snd_cnt = 0;
      busy_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         if (sendSignal) snd_cnt++;
         if (busy) busy_cnt++;
      end
      dataSent = 1'b0;
      chk("midwait_no_send", 16'(snd_cnt), 16'd0);
      chk("midwait_idle", 16'(busy_cnt), 16'd0);

`ifdef DEBUG_CYCLE_COUNT_EN
      halt = 1'b0;
      send_byte(B_CONT, 1'b1);
      en_cnt = 0;
      i = 0;
      while (!sendSignal && i < 70000) begin
         if (cpu_en) begin
            en_cnt++;
            if (en_cnt == 65535) chk("cc_preload", cycle_count, 16'hFFFE);
            if (en_cnt == 65536) halt = 1'b1;
         end
         cyc();
         i++;
      end
      chk("cc_wrap", cycle_count, 16'd0);
      halt = 1'b1;
      wait_idle("cc_run_done");
      halt = 1'b0;
      send_byte(B_RST, 1'b1);
      cyc();
      send_byte(B_STEP, 1'b1);
      wait_idle("cc_step1");
      send_byte(B_STEP, 1'b1);
      wait_idle("cc_step2");
      chk("cc_two_steps", cycle_count, 16'd2);
      send_byte(B_RST, 1'b1);
      cyc();
      chk("cc_cleared_by_cpu_reset", cycle_count, 16'd0);
`endif

      chk("en_send_overlap", 16'(overlap), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
